fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side drain stage for `async_fifo`, clocked entirely in the `rclk` domain. It pops bytes from the FIFO read port and packs `LANES` consecutive bytes into one wide word. It presents each word on a valid/ready output with a byte-keep mask. Partial words are emitted on an explicit `flush` or after a programmable idle timeout.

## Interface
- `DSIZE`, 8: FIFO data width (bits per lane).
- `LANES`, 4: lanes per output word; must be ≥ 2. Output width is `DSIZE*LANES`.
- `FLUSH_CYCLES`, 16: idle-timeout threshold in cycles; 0 disables the timeout.

Ports:
- `rclk`  in  1  read-domain clock; the only clock.
- `rrst_n`  in  1  synchronous, active-low reset, sampled on `rclk` rising edge.
- `rempty`  in  1  FIFO empty flag.
- `rdata`  in  DSIZE  FIFO head data. It is show-ahead: valid whenever `rempty`=0 and advances after a `rinc` edge.
- `rinc`  out  1  FIFO pop strobe (combinational).
- `flush`  in  1  level request to emit a partial word.
- `m_data`  out  DSIZE*LANES  packed word; lane 0 occupies bits [DSIZE-1:0].
- `m_keep`  out  LANES  valid-lane mask, thermometer from bit 0.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accept.

## Operation
- State:
  - accumulator `acc` (LANES×DSIZE) with fill count `cnt` (0..LANES).
  - one output slot (`m_data`/`m_keep`/`m_valid`).
  - idle counter `idle` (width clog2(FLUSH_CYCLES+1)).
- `slot_free` = !m_valid | m_ready.
- `timeout_hit` = (FLUSH_CYCLES≠0) & (idle == FLUSH_CYCLES).
- `xfer` = slot_free & ((cnt==LANES) | (cnt≠0 & (flush | timeout_hit))).
- `rinc` = rrst_n & !rempty & ((cnt<LANES) | xfer).
- Pop with no `xfer`: `acc[cnt]` ← `rdata`, `cnt` ← `cnt`+1.
- On `xfer`:
  - `m_data` ← `acc`, with unfilled lanes driven to 0.
  - `m_keep` ← (1<<cnt)−1.
  - `m_valid` ← 1.
  - If there is a concurrent pop, its byte goes to lane 0 of a fresh accumulator and `cnt` ← 1; otherwise `cnt` ← 0.
  - A partial flush never includes the byte popped in the same cycle.
- Slot handshake:
  - `m_valid` & `m_ready` with no `xfer`: `m_valid` ← 0.
  - `m_valid` & `m_ready` with `xfer`: new word loaded, `m_valid` stays 1.
  - While `m_valid` & !`m_ready`, `m_data`/`m_keep` are held stable.
- Idle counter:
  - Reset to 0 on any pop, any `xfer`, or when `cnt`==0.
  - Otherwise increments, saturating at FLUSH_CYCLES.
- `flush` with `cnt`==0 has no effect. `flush` held while the slot is stalled waits for `slot_free`.
- Backpressure: the accumulator fills to LANES, then `rinc` stays low until `xfer`. No byte is ever dropped or duplicated.

## Timing
- Reset (rrst_n=0 at an edge) clears: `m_valid`=0, `m_data`=0, `m_keep`=0, `cnt`=0, `idle`=0. `rinc` is forced 0 while rrst_n=0.
- Reset mid-operation discards the partial accumulator and any held word. The FIFO shares `rrst_n`, so its contents are discarded too.
- Latency: last lane popped at edge k → `xfer` condition true in cycle k → `m_valid`=1 after edge k+1, provided the slot is free.
- Throughput: with the FIFO non-empty and `m_ready`=1, one pop every cycle and one word every LANES cycles, with no bubbles.
- Timeout: with `cnt`>0 and no pops, `idle` reaches FLUSH_CYCLES after FLUSH_CYCLES edges; `xfer` fires at the next edge if the slot is free.
- FIFO empty mid-word: `rinc`=0, `acc`/`cnt` hold, `idle` counts.

## Test plan
- Reset, then write 0x11,0x22,0x33,0x44 to FIFO, `m_ready`=1 → one word 0x44332211, keep 4'b1111. `rinc` high for exactly 4 cycles; `m_valid` high 1 cycle.
- Stream 0x00..0x0F continuously, `m_ready`=1 → words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive 4-cycle boundaries, with no gap in `rinc`.
- Write 0xA1,0xA2 then stop, FLUSH_CYCLES=16 → after 16 idle cycles, word 0x0000A2A1 with keep 4'b0011 is emitted. Then `idle`=0 and `cnt`=0.
- Hold `m_ready`=0, stream 12 bytes 0x00..0x0B → first word held stable and second accumulated, then `rinc` stays low with 4 bytes remaining in the FIFO. Release `m_ready` → all three words arrive in order.
- Assert `flush` in the same cycle the FIFO presents 0xC3 with `cnt`=2 (acc 0xC1,0xC2) → emits 0x0000C2C1, keep 4'b0011; next word starts with 0xC3 in lane 0.
- Pulse `rrst_n`=0 with `cnt`=3 and a word held → `m_valid`, `m_keep`, `m_data` are 0 the next cycle. A fresh 4-byte burst then packs from lane 0.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side drain stage: pops show-ahead FIFO bytes and packs LANES of them into one
// wide valid/ready word, emitting partial words on flush or after an idle timeout.
module fifo_rd_packer #(
    parameter int DSIZE        = 8,
    parameter int LANES        = 4,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   rempty,
    input  logic [DSIZE-1:0]       rdata,
    output logic                   rinc,
    input  logic                   flush,
    output logic [DSIZE*LANES-1:0] m_data,
    output logic [LANES-1:0]       m_keep,
    output logic                   m_valid,
    input  logic                   m_ready
);

    localparam int CW = $clog2(LANES + 1);
    localparam int IW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    logic [DSIZE-1:0]       acc_r [LANES];
    logic [CW-1:0]          cnt_r;
    logic [IW-1:0]          idle_r;
    logic                   slot_free_s;
    logic                   full_s;
    logic                   timeout_hit_s;
    logic                   xfer_s;
    logic [LANES-1:0]       keep_s;
    logic [DSIZE*LANES-1:0] data_s;

    // Handshake and transfer decisions for the current cycle.
    always_comb begin
        slot_free_s   = !m_valid || m_ready;
        full_s        = (cnt_r == CW'(LANES));
        timeout_hit_s = (FLUSH_CYCLES != 0) && (idle_r == IW'(FLUSH_CYCLES));
        xfer_s        = slot_free_s &&
                        (full_s || ((cnt_r != CW'(0)) && (flush || timeout_hit_s)));
        rinc          = rrst_n && !rempty && (!full_s || xfer_s);
    end

    // Outgoing word: filled lanes only, unfilled lanes forced to zero.
    always_comb begin
        keep_s = '0;
        data_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < cnt_r) begin
                keep_s[i]                  = 1'b1;
                data_s[i*DSIZE +: DSIZE]   = acc_r[i];
            end else begin
                keep_s[i]                  = 1'b0;
                data_s[i*DSIZE +: DSIZE]   = '0;
            end
        end
    end

    // Accumulator, output slot and idle counter.
    always_ff @(posedge rclk) begin
        if (!rrst_n) begin
            for (int i = 0; i < LANES; i++) begin
                acc_r[i] <= '0;
            end
            cnt_r   <= '0;
            idle_r  <= '0;
            m_data  <= '0;
            m_keep  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (xfer_s) begin
                m_data  <= data_s;
                m_keep  <= keep_s;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end else begin
                m_valid <= m_valid;
            end

            // A byte popped alongside a transfer starts the next word.
            if (xfer_s) begin
                if (rinc) begin
                    acc_r[0] <= rdata;
                    cnt_r    <= CW'(1);
                end else begin
                    cnt_r    <= '0;
                end
            end else if (rinc) begin
                for (int i = 0; i < LANES; i++) begin
                    if (CW'(i) == cnt_r) begin
                        acc_r[i] <= rdata;
                    end
                end
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end

            if (rinc || xfer_s || (cnt_r == CW'(0))) begin
                idle_r <= '0;
            end else if (idle_r != IW'(FLUSH_CYCLES)) begin
                idle_r <= idle_r + IW'(1);
            end else begin
                idle_r <= idle_r;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: behavioural show-ahead FIFO in front,
// scoreboard of accepted words behind.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst_n;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;

    fifo_rd_packer #(.DSIZE(8), .LANES(4), .FLUSH_CYCLES(16)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid),
        .m_ready(m_ready)
    );

    always #5 rclk = ~rclk;

    logic [7:0]  fq[$];
    logic [31:0] got_d[$];
    logic [3:0]  got_k[$];
    int nchk = 0;
    int nfail = 0;
    int tcount, pops, vcount, first_valid, first_pop, last_pop;
    logic last_rinc;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [31:0] exp_data;
        logic [3:0]  exp_keep;
        int          exp_lat;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic upd_fifo();
        rempty = (fq.size() == 0);
        rdata  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        upd_fifo();
    endtask

    task automatic clear_stats();
        tcount = 0; pops = 0; vcount = 0;
        first_valid = -1; first_pop = -1; last_pop = -1;
        got_d.delete(); got_k.delete();
    endtask

    // One clock: sample before the edge, advance the FIFO model after it.
    task automatic tick();
        logic r;
        @(negedge rclk);
        r = rinc;
        last_rinc = r;
        if (r) begin
            pops++;
            if (first_pop < 0) first_pop = tcount;
            last_pop = tcount;
        end
        if (m_valid) begin
            vcount++;
            if (first_valid < 0) first_valid = tcount;
            if (m_ready) begin
                got_d.push_back(m_data);
                got_k.push_back(m_keep);
            end
        end
        @(posedge rclk);
        #1;
        if (!rrst_n) fq.delete();
        else if (r && fq.size() > 0) void'(fq.pop_front());
        tcount++;
        upd_fifo();
    endtask

    task automatic check_word(input string name, input int idx, input logic [31:0] d, input logic [3:0] k);
        if (got_d.size() > idx) begin
            check({name, "_data"}, got_d[idx], d);
            check({name, "_keep"}, {28'd0, got_k[idx]}, {28'd0, k});
        end else begin
            check({name, "_present"}, 32'(got_d.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        vecs[0] = '{n: 4, bytes: 32'h44332211, exp_data: 32'h44332211, exp_keep: 4'b1111, exp_lat: 5};
        vecs[1] = '{n: 2, bytes: 32'h0000A2A1, exp_data: 32'h0000A2A1, exp_keep: 4'b0011, exp_lat: 19};
        vecs[2] = '{n: 3, bytes: 32'h00030201, exp_data: 32'h00030201, exp_keep: 4'b0111, exp_lat: 20};
        vecs[3] = '{n: 1, bytes: 32'h000000FF, exp_data: 32'h000000FF, exp_keep: 4'b0001, exp_lat: 18};

        rrst_n = 1'b0; flush = 1'b0; m_ready = 1'b1;
        upd_fifo();
        clear_stats();
        tick(); tick();
        check("reset_valid", {31'd0, m_valid}, 32'd0);
        check("reset_keep", {28'd0, m_keep}, 32'd0);
        check("reset_data", m_data, 32'd0);
        check("reset_rinc", {31'd0, last_rinc}, 32'd0);
        rrst_n = 1'b1;

        // Table: full and partial words, latency measured from the push.
        for (int v = 0; v < 4; v++) begin
            logic [31:0] bb;
            clear_stats();
            bb = vecs[v].bytes;
            for (int j = 0; j < vecs[v].n; j++) push(bb[j*8 +: 8]);
            repeat (30) tick();
            check($sformatf("v%0d_words", v), 32'(got_d.size()), 32'd1);
            check_word($sformatf("v%0d", v), 0, vecs[v].exp_data, vecs[v].exp_keep);
            check($sformatf("v%0d_pops", v), 32'(pops), 32'(vecs[v].n));
            check($sformatf("v%0d_vcycles", v), 32'(vcount), 32'd1);
            check($sformatf("v%0d_latency", v), 32'(first_valid), 32'(vecs[v].exp_lat));
            check($sformatf("v%0d_cnt", v), 32'(dut.cnt_r), 32'd0);
            check($sformatf("v%0d_idle", v), 32'(dut.idle_r), 32'd0);
        end

        // Continuous stream: no rinc bubbles, one word every four cycles.
        clear_stats();
        for (int j = 0; j < 16; j++) push(8'(j));
        repeat (25) tick();
        check("stream_pops", 32'(pops), 32'd16);
        check("stream_pop_span", 32'(last_pop - first_pop + 1), 32'd16);
        check("stream_words", 32'(got_d.size()), 32'd4);
        check_word("stream_w0", 0, 32'h03020100, 4'hF);
        check_word("stream_w1", 1, 32'h07060504, 4'hF);
        check_word("stream_w2", 2, 32'h0B0A0908, 4'hF);
        check_word("stream_w3", 3, 32'h0F0E0D0C, 4'hF);
        check("stream_vcycles", 32'(vcount), 32'd4);

        // Backpressure: one word held, one accumulated, FIFO keeps the rest.
        clear_stats();
        m_ready = 1'b0;
        for (int j = 0; j < 12; j++) push(8'(j));
        repeat (10) tick();
        check("bp_hold_mid", m_data, 32'h03020100);
        repeat (10) tick();
        check("bp_pops", 32'(pops), 32'd8);
        check("bp_fifo_left", 32'(fq.size()), 32'd4);
        check("bp_hold_data", m_data, 32'h03020100);
        check("bp_hold_keep", {28'd0, m_keep}, 32'hF);
        check("bp_hold_valid", {31'd0, m_valid}, 32'd1);
        check("bp_cnt_full", 32'(dut.cnt_r), 32'd4);
        check("bp_rinc_low", {31'd0, last_rinc}, 32'd0);
        m_ready = 1'b1;
        repeat (20) tick();
        check("bp_words", 32'(got_d.size()), 32'd3);
        check_word("bp_w0", 0, 32'h03020100, 4'hF);
        check_word("bp_w1", 1, 32'h07060504, 4'hF);
        check_word("bp_w2", 2, 32'h0B0A0908, 4'hF);

        // Flush in the same cycle a new byte is popped.
        clear_stats();
        push(8'hC1); push(8'hC2);
        repeat (3) tick();
        push(8'hC3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, m_valid}, 32'd1);
        check("flush_data", m_data, 32'h0000C2C1);
        check("flush_keep", {28'd0, m_keep}, 32'h3);
        check("flush_cnt", 32'(dut.cnt_r), 32'd1);
        push(8'hC4); push(8'hC5); push(8'hC6);
        repeat (10) tick();
        check("flush_words", 32'(got_d.size()), 32'd2);
        check_word("flush_w0", 0, 32'h0000C2C1, 4'h3);
        check_word("flush_w1", 1, 32'hC6C5C4C3, 4'hF);

        // Reset mid-operation with a held word and a partial accumulator.
        clear_stats();
        m_ready = 1'b0;
        for (int j = 0; j < 7; j++) push(8'hD0 + 8'(j));
        repeat (8) tick();
        check("rst_pre_valid", {31'd0, m_valid}, 32'd1);
        check("rst_pre_cnt", 32'(dut.cnt_r), 32'd3);
        push(8'h99);
        rrst_n = 1'b0;
        tick();
        check("rst_rinc", {31'd0, last_rinc}, 32'd0);
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_keep", {28'd0, m_keep}, 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_cnt", 32'(dut.cnt_r), 32'd0);
        rrst_n = 1'b1;
        m_ready = 1'b1;
        clear_stats();
        for (int j = 0; j < 4; j++) push(8'hE0 + 8'(j));
        repeat (8) tick();
        check("rst_words", 32'(got_d.size()), 32'd1);
        check_word("rst_w0", 0, 32'hE3E2E1E0, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
